round_sequencer: RTL and testbench

- Game-flow controller for the two-player card/bell game.
- Sequences each round: waits for the active player's flip key, pulses the deal enable for the random generator and card counter, then waits for the card datapath to settle.
- Opens a timed bell window, arbitrates bell presses between the two players, issues a scoring strobe to the score path, toggles the turn and detects deck exhaustion.

---
 rtl/round_sequencer.sv | 147 ++++++++++++++
 tb/tb_round_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/round_sequencer.sv
// rtl/round_sequencer.sv - round/bell game-flow controller for the two-player card game
module round_sequencer #(
  parameter int DECK_SIZE   = 56,
  parameter int SETTLE_CYC  = 4,
  parameter int BELL_WINDOW = 5000000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] flip_req,
  input  logic [1:0] bell_req,
  input  logic       match,
  output logic       deal_en,
  output logic       turn,
  output logic       award,
  output logic       award_who,
  output logic       award_pos,
  output logic [7:0] cards_left,
  output logic       game_over,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_WAIT_FLIP = 3'd1;
  localparam logic [2:0] S_DEAL      = 3'd2;
  localparam logic [2:0] S_SETTLE    = 3'd3;
  localparam logic [2:0] S_BELL_WIN  = 3'd4;
  localparam logic [2:0] S_SCORE     = 3'd5;
  localparam logic [2:0] S_NEXT      = 3'd6;
  localparam logic [2:0] S_OVER      = 3'd7;

  localparam logic [7:0]       DECK_INIT   = 8'(DECK_SIZE);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] WIN_LOAD    = CNT_W'(BELL_WINDOW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  logic [2:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       flip_q;
  logic [1:0]       bell_q;
  logic             tie_ptr;
  logic             pend_valid;
  logic             pend_who;

  logic [1:0]       flip_edge;
  logic [1:0]       bell_edge;
  logic             bell_any;
  logic             grant_tie;
  logic             grant_who;

  assign state_dbg = state;

  // Rising-edge detection on the key levels and bell arbitration (ties go to the tie pointer)
  always_comb begin
    flip_edge = flip_req & ~flip_q;
    bell_edge = bell_req & ~bell_q;
    bell_any  = |bell_edge;
    grant_tie = &bell_edge;
    grant_who = grant_tie ? tie_ptr : bell_edge[1];
  end

  // Round sequencing FSM with registered outputs; pulses default low every cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      flip_q     <= 2'b00;
      bell_q     <= 2'b00;
      tie_ptr    <= 1'b0;
      pend_valid <= 1'b0;
      pend_who   <= 1'b0;
      deal_en    <= 1'b0;
      turn       <= 1'b0;
      award      <= 1'b0;
      award_who  <= 1'b0;
      award_pos  <= 1'b0;
      cards_left <= DECK_INIT;
      game_over  <= 1'b0;
    end else begin
      flip_q  <= flip_req;
      bell_q  <= bell_req;
      deal_en <= 1'b0;
      award   <= 1'b0;
      case (state)
        S_IDLE: state <= S_WAIT_FLIP;
        S_WAIT_FLIP: begin
          if (flip_edge[turn]) begin
            deal_en <= 1'b1;
            state   <= S_DEAL;
          end
        end
        S_DEAL: begin
          cards_left <= cards_left - 8'd1;
          cnt        <= SETTLE_LOAD;
          state      <= S_SETTLE;
        end
        S_SETTLE: begin
          // Cards are not trusted yet, so an early ring is only remembered
          if (bell_any && !pend_valid) begin
            pend_valid <= 1'b1;
            pend_who   <= grant_who;
            if (grant_tie) tie_ptr <= ~tie_ptr;
          end
          if (cnt == '0) begin
            if (pend_valid || bell_any) begin
              award     <= 1'b1;
              award_who <= pend_valid ? pend_who : grant_who;
              award_pos <= match;
              state     <= S_SCORE;
            end else begin
              cnt   <= WIN_LOAD;
              state <= S_BELL_WIN;
            end
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_BELL_WIN: begin
          if (bell_any) begin
            award     <= 1'b1;
            award_who <= grant_who;
            award_pos <= match;
            if (grant_tie) tie_ptr <= ~tie_ptr;
            state     <= S_SCORE;
          end else if (cnt == '0) begin
            state <= S_NEXT;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        S_SCORE: state <= S_NEXT;
        S_NEXT: begin
          turn       <= ~turn;
          pend_valid <= 1'b0;
          if (cards_left == 8'd0) begin
            game_over <= 1'b1;
            state     <= S_OVER;
          end else begin
            state <= S_WAIT_FLIP;
          end
        end
        S_OVER: state <= S_OVER;
      endcase
    end
  end

endmodule

// File: tb/tb_round_sequencer.sv
// tb/tb_round_sequencer.sv - self-checking bench for round_sequencer
module tb_round_sequencer;

  localparam int DECK   = 3;
  localparam int SETTLE = 2;
  localparam int WINDOW = 8;

  logic       clk;
  logic       rst;
  logic [1:0] flip_req;
  logic [1:0] bell_req;
  logic       match;
  logic       deal_en;
  logic       turn;
  logic       award;
  logic       award_who;
  logic       award_pos;
  logic [7:0] cards_left;
  logic       game_over;
  logic [2:0] state_dbg;

  int n_checks = 0;
  int n_errors = 0;

  round_sequencer #(
    .DECK_SIZE(DECK),
    .SETTLE_CYC(SETTLE),
    .BELL_WINDOW(WINDOW),
    .CNT_W(24)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flip_req(flip_req),
    .bell_req(bell_req),
    .match(match),
    .deal_en(deal_en),
    .turn(turn),
    .award(award),
    .award_who(award_who),
    .award_pos(award_pos),
    .cards_left(cards_left),
    .game_over(game_over),
    .state_dbg(state_dbg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Timeline reference model: a round is described by the cycle of its accepted
  // flip and the cycle its score strobe is due; the phase follows from offsets.
  int   m_t, m_flip_at, m_score_at, m_cards;
  bit   m_idle, m_over, m_cap, m_who, m_pos, m_tie, m_turn;
  logic [1:0] m_pf, m_pb;

  function automatic int m_phase();
    int off;
    if (m_idle) return 0;
    if (m_over) return 7;
    if (m_flip_at < 0) return 1;
    if (m_score_at >= 0 && m_t >= m_score_at) return (m_t == m_score_at) ? 5 : 6;
    off = m_t - m_flip_at;
    if (off == 1) return 2;
    if (off <= 1 + SETTLE) return 3;
    if (off <= 1 + SETTLE + WINDOW) return 4;
    return 6;
  endfunction

  task automatic m_grant(input logic [1:0] be);
    if (be == 2'b11) begin
      m_who = m_tie;
      m_tie = !m_tie;
    end else begin
      m_who = be[1];
    end
    m_cap = 1;
  endtask

  task automatic model_step(input logic r, input logic [1:0] f, input logic [1:0] b, input logic m);
    logic [1:0] fe, be;
    int p;
    if (r) begin
      m_t = 0; m_flip_at = -1; m_score_at = -1; m_cards = DECK;
      m_idle = 1; m_over = 0; m_cap = 0; m_who = 0; m_pos = 0; m_tie = 0; m_turn = 0;
      m_pf = 2'b00; m_pb = 2'b00;
      return;
    end
    fe = f & ~m_pf;
    be = b & ~m_pb;
    m_pf = f;
    m_pb = b;
    p = m_phase();
    case (p)
      0: m_idle = 0;
      1: if (fe[m_turn]) m_flip_at = m_t;
      2: m_cards = m_cards - 1;
      3: begin
        if (be != 2'b00 && !m_cap) m_grant(be);
        if ((m_t - m_flip_at == 1 + SETTLE) && m_cap) begin
          m_score_at = m_t + 1;
          m_pos = m;
        end
      end
      4: if (be != 2'b00) begin
        m_grant(be);
        m_score_at = m_t + 1;
        m_pos = m;
      end
      6: begin
        m_turn = !m_turn;
        if (m_cards == 0) m_over = 1;
        m_flip_at = -1;
        m_score_at = -1;
        m_cap = 0;
      end
      default: ;
    endcase
    m_t++;
  endtask

  // Drive one cycle of inputs, advance the model and compare every output
  task automatic cycle(input logic r, input logic [1:0] f, input logic [1:0] b, input logic m);
    int q;
    rst = r; flip_req = f; bell_req = b; match = m;
    model_step(r, f, b, m);
    @(posedge clk);
    #1;
    q = m_phase();
    chk("state_dbg", int'(state_dbg), q);
    chk("deal_en", int'(deal_en), (q == 2) ? 1 : 0);
    chk("award", int'(award), (q == 5) ? 1 : 0);
    if (q == 5) begin
      chk("award_who", int'(award_who), int'(m_who));
      chk("award_pos", int'(award_pos), int'(m_pos));
    end
    chk("cards_left", int'(cards_left), m_cards);
    chk("turn", int'(turn), int'(m_turn));
    chk("game_over", int'(game_over), (q == 7) ? 1 : 0);
  endtask

  // Flip for player p and run through DEAL and SETTLE into the bell window
  task automatic start_round(input int p, input logic m);
    cycle(1'b0, (p == 0) ? 2'b01 : 2'b10, 2'b00, m);
    chk("round_deal", int'(deal_en), 1);
    cycle(1'b0, 2'b00, 2'b00, m);
    cycle(1'b0, 2'b00, 2'b00, m);
    cycle(1'b0, 2'b00, 2'b00, m);
    chk("round_in_window", int'(state_dbg), 4);
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] flip;
    logic [1:0] bell;
    logic       match;
    logic [2:0] st;
    logic       deal;
    logic       award;
    logic [7:0] cards;
    logic       turn;
    logic       go;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic [1:0] f, input logic [1:0] b, input logic m,
                         input logic [2:0] st, input logic dl, input logic aw,
                         input logic [7:0] cl, input logic tn, input logic go);
    vec_t v;
    v.rst = r; v.flip = f; v.bell = b; v.match = m;
    v.st = st; v.deal = dl; v.award = aw; v.cards = cl; v.turn = tn; v.go = go;
    vecs.push_back(v);
  endtask

  initial begin
    int awards;
    logic [1:0] rf, rb;
    rst = 1'b1; flip_req = 2'b00; bell_req = 2'b00; match = 1'b0;

    // Reset, wrong-player flip, first deal with latency, then a silent bell window
    add_vec(1, 2'b00, 2'b00, 0, 3'd0, 0, 0, 8'd3, 0, 0);
    add_vec(0, 2'b00, 2'b00, 0, 3'd1, 0, 0, 8'd3, 0, 0);
    add_vec(0, 2'b10, 2'b00, 0, 3'd1, 0, 0, 8'd3, 0, 0);
    add_vec(0, 2'b00, 2'b00, 0, 3'd1, 0, 0, 8'd3, 0, 0);
    add_vec(0, 2'b01, 2'b00, 0, 3'd2, 1, 0, 8'd3, 0, 0);
    add_vec(0, 2'b01, 2'b00, 0, 3'd3, 0, 0, 8'd2, 0, 0);
    add_vec(0, 2'b00, 2'b00, 0, 3'd3, 0, 0, 8'd2, 0, 0);
    add_vec(0, 2'b00, 2'b00, 0, 3'd4, 0, 0, 8'd2, 0, 0);
    for (int i = 0; i < WINDOW - 1; i++)
      add_vec(0, 2'b00, 2'b00, 0, 3'd4, 0, 0, 8'd2, 0, 0);
    add_vec(0, 2'b00, 2'b00, 0, 3'd6, 0, 0, 8'd2, 0, 0);
    add_vec(0, 2'b00, 2'b00, 0, 3'd1, 0, 0, 8'd2, 1, 0);

    foreach (vecs[i]) begin
      cycle(vecs[i].rst, vecs[i].flip, vecs[i].bell, vecs[i].match);
      chk($sformatf("vec%0d_state", i), int'(state_dbg), int'(vecs[i].st));
      chk($sformatf("vec%0d_deal", i), int'(deal_en), int'(vecs[i].deal));
      chk($sformatf("vec%0d_award", i), int'(award), int'(vecs[i].award));
      chk($sformatf("vec%0d_cards", i), int'(cards_left), int'(vecs[i].cards));
      chk($sformatf("vec%0d_turn", i), int'(turn), int'(vecs[i].turn));
      chk($sformatf("vec%0d_over", i), int'(game_over), int'(vecs[i].go));
    end

    // P2 rings mid-window with a match; a later P1 ring in the same round is ignored
    start_round(1, 1'b1);
    for (int i = 0; i < 3; i++) cycle(1'b0, 2'b00, 2'b00, 1'b1);
    cycle(1'b0, 2'b00, 2'b10, 1'b1);
    chk("t3_award", int'(award), 1);
    chk("t3_who", int'(award_who), 1);
    chk("t3_pos", int'(award_pos), 1);
    awards = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'b00, (i % 2 == 0) ? 2'b11 : 2'b10, 1'b1);
      if (award) awards++;
    end
    chk("t3_no_second_award", awards, 0);
    chk("t3_turn_back", int'(turn), 0);

    // P1 rings during SETTLE; the award lands right after SETTLE ends
    cycle(1'b0, 2'b01, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b01, 1'b0);
    chk("t5_settle_no_award", int'(award), 0);
    chk("t5_settle_state", int'(state_dbg), 3);
    cycle(1'b0, 2'b00, 2'b01, 1'b0);
    chk("t5_award", int'(award), 1);
    chk("t5_who", int'(award_who), 0);
    chk("t5_pos", int'(award_pos), 0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    chk("t6_over_state", int'(state_dbg), 7);
    chk("t6_game_over", int'(game_over), 1);
    chk("t6_cards_zero", int'(cards_left), 0);
    for (int i = 0; i < 6; i++) begin
      cycle(1'b0, (i % 2 == 0) ? 2'b11 : 2'b00, 2'b00, 1'b0);
      chk("t6_no_deal", int'(deal_en), 0);
    end
    cycle(1'b1, 2'b00, 2'b00, 1'b0);
    chk("t6_rst_cards", int'(cards_left), 3);
    chk("t6_rst_turn", int'(turn), 0);
    chk("t6_rst_over", int'(game_over), 0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);

    // Simultaneous rings in two consecutive rounds alternate via the tie pointer
    start_round(0, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b11, 1'b0);
    chk("t4_award1", int'(award), 1);
    chk("t4_who1", int'(award_who), 0);
    chk("t4_pos1", int'(award_pos), 0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    start_round(1, 1'b0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);
    cycle(1'b0, 2'b00, 2'b11, 1'b0);
    chk("t4_award2", int'(award), 1);
    chk("t4_who2", int'(award_who), 1);
    chk("t4_pos2", int'(award_pos), 0);
    cycle(1'b0, 2'b00, 2'b00, 1'b0);

    // Randomized play, including mid-round resets, against the model
    rf = 2'b00;
    rb = 2'b00;
    for (int i = 0; i < 4000; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rf = 2'($urandom_range(0, 3));
      if (r < 6) rb = 2'($urandom_range(0, 3));
      else if (r < 25) rb = 2'b00;
      cycle(($urandom_range(0, 149) == 0) ? 1'b1 : 1'b0, rf, rb, 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
